// File: rtl/led_frame_scheduler.sv
// Sequences the LED double buffer and streams each frame as APA102 bytes.
// Swaps only between frames; optional refresh timer re-sends the current frame.
module led_frame_scheduler #(
    parameter int LEDS           = 200,
    parameter int ADDR_WIDTH     = $clog2(LEDS*3),
    parameter int END_BYTES      = (LEDS+15)/16,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_done,
    output logic                  o_wr_ready,
    output logic                  o_swap,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [7:0]            i_rd_data,
    input  logic [4:0]            i_brightness,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_frame_start,
    output logic                  o_frame_end,
    output logic                  o_frame_dropped
);

    localparam int CNT_MAX = (END_BYTES > 4) ? END_BYTES : 4;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit REFRESH_EN = (REFRESH_CYCLES > 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LEDS*3 - 1);
    localparam logic [CNT_W-1:0]      START_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0]      END_LAST   = CNT_W'(END_BYTES - 1);
    localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SWAP, S_START, S_HDR, S_RD0, S_RD1, S_DATA, S_END
    } state_t;

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic                  wr_ready_q;
    logic                  start_q, drop_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [4:0]            bri_q, bri_d;
    logic [7:0]            data_q, data_d;
    logic                  start_d, drop_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        addr_d      = addr_q;
        tmr_d       = '0;
        bri_d       = bri_q;
        data_d      = data_q;
        o_swap      = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A notice arriving in this very cycle already beats refresh expiry.
                if (pending_q || i_frame_done) begin
                    state_d = S_SWAP;
                end else if (REFRESH_EN && tmr_q == TMR_LAST) begin
                    state_d = S_START;
                end else if (REFRESH_EN) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SWAP: begin
                o_swap  = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    if (cnt_q == START_LAST) begin
                        cnt_d   = '0;
                        state_d = S_HDR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {3'b111, bri_q};
                if (i_tx_ready) begin
                    col_d   = 2'd0;
                    state_d = S_RD0;
                end
            end
            S_RD0: state_d = S_RD1;
            S_RD1: begin
                data_d  = i_rd_data;
                state_d = S_DATA;
            end
            S_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = data_q;
                if (i_tx_ready) begin
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_END;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_HDR;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD0;
                    end
                end
            end
            S_END: begin
                o_tx_valid = 1'b1;
                o_tx_data  = 8'hFF;
                if (i_tx_ready) begin
                    if (cnt_q == END_LAST) begin
                        cnt_d       = '0;
                        o_frame_end = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Both swap-driven and refresh frames latch brightness on START entry.
        start_d = (state_d == S_START) && (state_q != S_START);
        if (start_d) begin
            bri_d  = i_brightness;
            cnt_d  = '0;
            col_d  = 2'd0;
            addr_d = '0;
        end

        pending_d = (state_q == S_SWAP) ? i_frame_done : (pending_q | i_frame_done);
        drop_d    = i_frame_done && pending_q && (state_q != S_SWAP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            start_q    <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            col_q      <= 2'd0;
            addr_q     <= '0;
            tmr_q      <= '0;
            bri_q      <= 5'd0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            wr_ready_q <= !pending_d;
            start_q    <= start_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            tmr_q      <= tmr_d;
            bri_q      <= bri_d;
            data_q     <= data_d;
        end
    end

    assign o_wr_ready      = wr_ready_q;
    assign o_rd_addr       = addr_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_frame_start   = start_q;
    assign o_frame_dropped = drop_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: LEDS=4, one instance without refresh and one with a 100-cycle refresh.
module tb_led_frame_scheduler;

    logic       clk;
    logic       rst;
    logic       done;
    logic       rdy;
    logic       sel;
    logic [4:0] bri;

    logic       a_done, a_rdy, a_wr_ready, a_swap, a_valid, a_busy, a_fs, a_fe, a_drop;
    logic [3:0] a_addr;
    logic [7:0] a_rd, a_data;
    logic       b_done, b_rdy, b_wr_ready, b_swap, b_valid, b_busy, b_fs, b_fe, b_drop;
    logic [3:0] b_addr;
    logic [7:0] b_rd, b_data;

    logic [7:0] m_data;
    logic       m_valid, m_end, m_wr_ready;

    logic [7:0] mem [12];

    int n_cmp = 0;
    int n_bad = 0;
    int a_swaps = 0, a_drops = 0, a_starts = 0, b_swaps = 0;

    typedef struct {
        int         stall;
        logic [7:0] dat;
        logic       last;
    } vec_t;
    vec_t       tbl [21];
    logic [7:0] exp_bytes [21];

    assign a_done = done & ~sel;
    assign b_done = done & sel;
    assign a_rdy  = rdy & ~sel;
    assign b_rdy  = rdy & sel;
    assign m_data     = sel ? b_data : a_data;
    assign m_valid    = sel ? b_valid : a_valid;
    assign m_end      = sel ? b_fe : a_fe;
    assign m_wr_ready = sel ? b_wr_ready : a_wr_ready;

    led_frame_scheduler #(.LEDS(4), .REFRESH_CYCLES(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_frame_done(a_done), .o_wr_ready(a_wr_ready),
        .o_swap(a_swap), .o_rd_addr(a_addr), .i_rd_data(a_rd), .i_brightness(bri),
        .o_tx_data(a_data), .o_tx_valid(a_valid), .i_tx_ready(a_rdy), .o_busy(a_busy),
        .o_frame_start(a_fs), .o_frame_end(a_fe), .o_frame_dropped(a_drop)
    );

    led_frame_scheduler #(.LEDS(4), .REFRESH_CYCLES(100)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_frame_done(b_done), .o_wr_ready(b_wr_ready),
        .o_swap(b_swap), .o_rd_addr(b_addr), .i_rd_data(b_rd), .i_brightness(bri),
        .o_tx_data(b_data), .o_tx_valid(b_valid), .i_tx_ready(b_rdy), .o_busy(b_busy),
        .o_frame_start(b_fs), .o_frame_end(b_fe), .o_frame_dropped(b_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read buffer model, one port per instance.
    always @(posedge clk) begin
        a_rd <= mem[a_addr];
        b_rd <= mem[b_addr];
    end

    always @(negedge clk) begin
        if (a_swap)  a_swaps++;
        if (a_drop)  a_drops++;
        if (a_fs)    a_starts++;
        if (b_swap)  b_swaps++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    // Collects nbytes from the selected instance. pct<0 uses the table stall counts.
    task automatic run_frame(input int pct, input int nbytes, input int inj1, input int inj2, input string tag);
        int got, cyc, st, last_got, inj_cyc;
        logic stalled;
        logic [7:0] hold;
        got = 0; cyc = 0; st = 0; last_got = -1; inj_cyc = -10;
        stalled = 1'b0; hold = 8'h00;
        while (got < nbytes && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            done = 1'b0;
            if (cyc == inj_cyc + 1) check({tag, "_wr_ready_low"}, {31'd0, m_wr_ready}, 32'd0);
            if (got == inj1) begin
                done = 1'b1; inj1 = -1; inj_cyc = cyc;
            end else if (got == inj2) begin
                done = 1'b1; inj2 = -1;
            end
            if (got == 6) bri = 5'h03;
            if (pct < 0) begin
                if (got != last_got) begin
                    st = tbl[got].stall;
                    last_got = got;
                end
                rdy = (st == 0);
                if (st > 0) st--;
            end else begin
                rdy = ($urandom_range(99) < pct);
            end
            #1;
            if (stalled) begin
                check($sformatf("%s_stall_dat%0d", tag, got), {24'd0, m_data}, {24'd0, hold});
                check($sformatf("%s_stall_vld%0d", tag, got), {31'd0, m_valid}, 32'd1);
            end
            stalled = 1'b0;
            if (m_valid) begin
                if (rdy) begin
                    check($sformatf("%s_byte%0d", tag, got), {23'd0, m_end, m_data},
                          {23'd0, tbl[got].last, tbl[got].dat});
                    got++;
                end else begin
                    stalled = 1'b1;
                    hold = m_data;
                end
            end
        end
        if (got < nbytes) check({tag, "_timeout_bytes"}, got, nbytes);
        @(posedge clk);
        #1;
        rdy = 1'b0;
        done = 1'b0;
        bri = 5'h1F;
    endtask

    initial begin
        int found;
        exp_bytes = '{8'h00, 8'h00, 8'h00, 8'h00,
                      8'hFF, 8'h01, 8'h02, 8'h03,
                      8'hFF, 8'h04, 8'h05, 8'h06,
                      8'hFF, 8'h07, 8'h08, 8'h09,
                      8'hFF, 8'h0A, 8'h0B, 8'h0C,
                      8'hFF};
        for (int i = 0; i < 21; i++) begin
            tbl[i].dat   = exp_bytes[i];
            tbl[i].last  = (i == 20);
            tbl[i].stall = (i % 5 == 3) ? 2 : ((i % 7 == 1) ? 1 : 0);
        end
        for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);

        rst = 1'b1; done = 1'b0; rdy = 1'b0; sel = 1'b0; bri = 5'h1F;
        repeat (2) @(negedge clk);
        check("rst_wr_ready", {31'd0, a_wr_ready}, 32'd1);
        check("rst_outputs", {a_swap, a_valid, a_busy, a_fs, a_fe, a_drop, a_addr, a_data}, 32'd0);
        rst = 1'b0;

        // Basic frame, always ready
        pulse_done();
        run_frame(100, 21, -1, -1, "basic");
        check("basic_swaps", a_swaps, 1);
        @(negedge clk);
        check("basic_busy_after", {31'd0, a_busy}, 32'd0);
        check("basic_starts", a_starts, 1);

        // Random 30% ready, then table-driven stalls
        pulse_done();
        run_frame(30, 21, -1, -1, "rand");
        check("rand_swaps", a_swaps, 2);
        pulse_done();
        run_frame(-1, 21, -1, -1, "tbl");
        check("tbl_swaps", a_swaps, 3);

        // Frame notice mid-stream: swap deferred until after frame end
        pulse_done();
        run_frame(100, 21, 10, -1, "mid");
        check("mid_swaps_in_frame", a_swaps, 4);
        check("mid_drops", a_drops, 0);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            if (a_swap) found = 1;
        end
        check("mid_swap_seen", found, 1);
        @(negedge clk);
        check("mid_wr_ready_back", {31'd0, a_wr_ready}, 32'd1);
        run_frame(100, 21, -1, -1, "after");
        check("after_swaps", a_swaps, 5);

        // Two notices in one frame: one drop, one swap afterwards
        pulse_done();
        run_frame(100, 21, 5, 12, "two");
        check("two_drops", a_drops, 1);
        run_frame(100, 21, -1, -1, "two_next");
        repeat (20) @(negedge clk);
        check("two_swaps", a_swaps, 7);
        check("two_busy_idle", {31'd0, a_busy}, 32'd0);

        // Reset mid-frame at byte 7
        pulse_done();
        run_frame(100, 7, -1, -1, "pre_rst");
        rst = 1'b1;
        #1;
        check("midrst_outputs", {a_swap, a_valid, a_busy, a_fs, a_fe, a_drop, a_addr, a_data}, 32'd0);
        check("midrst_wr_ready", {31'd0, a_wr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        pulse_done();
        run_frame(100, 21, -1, -1, "post_rst");

        // Refresh instance: frames without any notice, gap of 100 idle cycles
        sel = 1'b1;
        run_frame(100, 21, -1, -1, "refresh1");
        found = 0;
        for (int k = 1; k <= 200 && found == 0; k++) begin
            @(negedge clk);
            if (b_fs) found = k;
        end
        check("refresh_gap", found, 101);
        check("refresh_no_swap", b_swaps, 0);
        run_frame(100, 21, -1, -1, "refresh2");
        repeat (100) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("expiry_swap_first", {30'd0, b_swap, b_fs}, 32'd2);
        @(negedge clk);
        check("expiry_start_after", {31'd0, b_fs}, 32'd1);
        check("expiry_swaps", b_swaps, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
